// File: rtl/corelet_pkg.sv
// corelet_pkg: shared definitions for the corelet instruction sequencer.
//  - bit positions of the 35-bit corelet inst word
//  - reset value of inst (both SRAMs disabled)
//  - sequencer state encoding
package corelet_pkg;

  localparam int INST_W        = 35;
  localparam int INST_MODE     = 34;
  localparam int INST_ACC      = 33;
  localparam int INST_CEN_P    = 32;
  localparam int INST_WEN_P    = 31;
  localparam int INST_AP_LO    = 20;  // A_pmem occupies [30:20]
  localparam int INST_CEN_X    = 19;
  localparam int INST_WEN_X    = 18;
  localparam int INST_AX_LO    = 7;   // A_xmem occupies [17:7]
  localparam int INST_OFIFO_RD = 6;
  localparam int INST_L0_RD    = 3;
  localparam int INST_L0_WR    = 2;
  localparam int INST_EXEC     = 1;
  localparam int INST_LOAD     = 0;

  // CEN/WEN of both SRAMs high, everything else low.
  localparam logic [INST_W-1:0] INST_RST = 35'h1_800C_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WLD,
    ST_WARR,
    ST_FLUSH,
    ST_ALD,
    ST_EXEC,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/corelet_ctrl_cnt.sv
// ctrl_cnt: loadable phase down-counter shared by every sequencer phase.
//  clk, reset  : clock, async active-high reset
//  load        : load load_val (has priority over dec)
//  load_val    : phase length
//  dec         : count one unit of work; saturates at zero
//  zero        : counter is zero
//  last        : counter is one (current unit is the final one)
module ctrl_cnt #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (dec && !zero) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
  assign last = (cnt_q == W'(1));

endmodule

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: instruction sequencer for one weight-stationary conv layer.
// For each kernel position kij: WLD -> WARR -> FLUSH -> ALD -> EXEC -> DRAIN,
// then the next kij or DONE.
//  clk, reset      : clock, async active-high reset
//  start           : one-cycle request, honoured only when idle and act_len!=0
//  mode_select     : latched at start, driven on inst[34]
//  act_len         : activation words per kij (latched)
//  w_base/a_base   : xmem bases of weights / activations (latched)
//  p_base          : pmem base for psums (latched)
//  l0_full         : stalls xmem read issue during WLD/ALD
//  ofifo_valid     : OFIFO row available; each one drained into pmem
//  inst            : registered corelet instruction word
//  busy, done      : run in progress / one-cycle completion pulse
//  kij_idx         : current kernel position
module corelet_ctrl import corelet_pkg::*; #(
  parameter int row       = 8,
  parameter int col       = 8,
  parameter int ADDR_W    = 11,
  parameter int K_ITER    = 9,
  parameter int FLUSH_CYC = row + col
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_select,
  input  logic [ADDR_W-1:0] act_len,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] p_base,
  input  logic              l0_full,
  input  logic              ofifo_valid,
  output logic [34:0]       inst,
  output logic              busy,
  output logic              done,
  output logic [3:0]        kij_idx
);

  state_e            state_q, state_d;
  logic [3:0]        kij_q, kij_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] act_len_q, act_len_d;
  logic [ADDR_W-1:0] w_base_q, w_base_d;
  logic [ADDR_W-1:0] a_base_q, a_base_d;
  logic [ADDR_W-1:0] xaddr_q, xaddr_d;   // next xmem address to issue
  logic [ADDR_W-1:0] paddr_q, paddr_d;   // running psum address across kij
  logic              rd_pend_q, rd_pend_d; // xmem read in flight -> l0_wr next
  logic [34:0]       inst_q, inst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              cnt_load, cnt_dec, cnt_zero, cnt_last;
  logic [ADDR_W-1:0] cnt_val;
  logic              start_ok, last_kij, ld_phase, issue;
  logic [ADDR_W-1:0] wb_sel;

  ctrl_cnt #(.W(ADDR_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  assign start_ok = (state_q == ST_IDLE) && !busy_q && start && (act_len != '0);
  assign last_kij = (kij_q == 4'(K_ITER - 1));
  assign ld_phase = (state_q == ST_WLD) || (state_q == ST_ALD);
  // Counter tracks words not yet written into L0; one of them may already be
  // in flight, so a new read is issued only while more remain than are pending.
  assign issue    = ld_phase && !cnt_zero && !(cnt_last && rd_pend_q) && !l0_full;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_WLD;
      ST_WLD:   if (rd_pend_q && cnt_last) state_d = ST_WARR;
      ST_WARR:  if (cnt_last) state_d = ST_FLUSH;
      ST_FLUSH: if (cnt_last) state_d = ST_ALD;
      ST_ALD:   if (rd_pend_q && cnt_last) state_d = ST_EXEC;
      ST_EXEC:  if (cnt_last) state_d = ST_DRAIN;
      ST_DRAIN: if (ofifo_valid && cnt_last) state_d = last_kij ? ST_DONE : ST_WLD;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath
  always_comb begin
    kij_d     = kij_q;
    mode_d    = mode_q;
    act_len_d = act_len_q;
    w_base_d  = w_base_q;
    a_base_d  = a_base_q;
    xaddr_d   = xaddr_q;
    paddr_d   = paddr_q;
    rd_pend_d = issue;
    inst_d    = INST_RST;
    inst_d[INST_MODE] = mode_q;
    cnt_load  = (state_d != state_q);
    cnt_val   = '0;
    cnt_dec   = 1'b0;
    wb_sel    = start_ok ? w_base : w_base_q;

    if (start_ok) begin
      kij_d     = '0;
      mode_d    = mode_select;
      act_len_d = act_len;
      w_base_d  = w_base;
      a_base_d  = a_base;
      paddr_d   = p_base;
    end
    if (state_q == ST_DRAIN && state_d == ST_WLD) kij_d = kij_q + 4'd1;

    case (state_d)
      ST_WLD, ST_WARR:           cnt_val = ADDR_W'(col);
      ST_FLUSH:                  cnt_val = ADDR_W'(FLUSH_CYC);
      ST_ALD, ST_EXEC, ST_DRAIN: cnt_val = act_len_q;
      default:                   cnt_val = '0;
    endcase

    if (cnt_load && state_d == ST_WLD)
      xaddr_d = wb_sel + ADDR_W'(kij_d) * ADDR_W'(col);
    else if (cnt_load && state_d == ST_ALD)
      xaddr_d = a_base_q;
    else if (issue)
      xaddr_d = xaddr_q + ADDR_W'(1);

    case (state_q)
      ST_WLD, ST_ALD: begin
        cnt_dec = rd_pend_q;
        inst_d[INST_AX_LO +: ADDR_W] = xaddr_q;  // held while stalled
        inst_d[INST_CEN_X] = !issue;
        inst_d[INST_L0_WR] = rd_pend_q;
      end
      ST_WARR: begin
        cnt_dec = 1'b1;
        inst_d[INST_L0_RD] = 1'b1;
        inst_d[INST_LOAD]  = 1'b1;
      end
      ST_FLUSH: cnt_dec = 1'b1;
      ST_EXEC: begin
        cnt_dec = 1'b1;
        inst_d[INST_L0_RD] = 1'b1;
        inst_d[INST_EXEC]  = 1'b1;
      end
      ST_DRAIN: begin
        if (ofifo_valid) begin
          cnt_dec = 1'b1;
          inst_d[INST_OFIFO_RD] = 1'b1;
          inst_d[INST_CEN_P]    = 1'b0;
          inst_d[INST_WEN_P]    = 1'b0;
          inst_d[INST_AP_LO +: ADDR_W] = paddr_q;
          paddr_d = paddr_q + ADDR_W'(1);
        end
      end
      default: ;
    endcase

    done_d = (state_q == ST_DONE);
    // Stay busy through the done pulse; drop the cycle after.
    busy_d = (state_d != ST_IDLE) || (state_q == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kij_q     <= '0;
      mode_q    <= 1'b0;
      act_len_q <= '0;
      w_base_q  <= '0;
      a_base_q  <= '0;
      xaddr_q   <= '0;
      paddr_q   <= '0;
      rd_pend_q <= 1'b0;
      inst_q    <= INST_RST;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      kij_q     <= kij_d;
      mode_q    <= mode_d;
      act_len_q <= act_len_d;
      w_base_q  <= w_base_d;
      a_base_q  <= a_base_d;
      xaddr_q   <= xaddr_d;
      paddr_q   <= paddr_d;
      rd_pend_q <= rd_pend_d;
      inst_q    <= inst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign inst    = inst_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign kij_idx = kij_q;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Scoreboard bench for corelet_ctrl. Stimulus pushes the expected xmem read
// addresses, pmem write addresses and WARR/EXEC segment lengths for a whole
// layer, computed from the layer rules; a negedge monitor decodes inst and
// pops/compares as events appear.
module tb_corelet_ctrl;
  localparam int ROW = 8, COL = 8, AW = 11, KI = 9, FL = ROW + COL;
  localparam int AMOD = 1 << AW;
  localparam logic [34:0] RST_INST = 35'h1_800C_0000;

  logic clk = 1'b0;
  logic reset, start, mode_select, l0_full, ofifo_valid;
  logic [AW-1:0] act_len, w_base, a_base, p_base;
  logic [34:0] inst;
  logic busy, done;
  logic [3:0] kij_idx;

  int n_cmp = 0, n_bad = 0;
  int exp_x[$], exp_p[$], seg_kind[$], seg_len[$];
  logic exp_mode = 1'b0;
  bit rand_full = 1'b0;
  int full_left = 0;
  int done_cnt = 0;
  bit saw_exec_k1 = 1'b0;

  // monitor state
  int m_run_kind = -1, m_run_len = 0, m_wr = 0, m_gap = 0;
  bit m_in_gap = 0, m_prev_xrd = 0, m_prev_done = 0;

  corelet_ctrl #(.row(ROW), .col(COL), .ADDR_W(AW), .K_ITER(KI)) dut (
    .clk(clk), .reset(reset), .start(start), .mode_select(mode_select),
    .act_len(act_len), .w_base(w_base), .a_base(a_base), .p_base(p_base),
    .l0_full(l0_full), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done), .kij_idx(kij_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Random back-pressure: ofifo_valid coin flip, l0_full in 3-cycle bursts.
  always @(posedge clk) begin
    #1;
    ofifo_valid = 1'($urandom_range(0, 1));
    if (full_left > 0) begin
      l0_full = 1'b1; full_left--;
    end else if (rand_full && $urandom_range(0, 9) == 0) begin
      l0_full = 1'b1; full_left = 2;
    end else l0_full = 1'b0;
  end

  always @(negedge clk) begin : mon
    logic xrd, prd;
    int cur;
    if (reset) begin
      m_run_kind = -1; m_run_len = 0; m_wr = 0; m_gap = 0;
      m_in_gap = 0; m_prev_xrd = 0; m_prev_done = 0;
    end else begin
      xrd = !inst[19];
      prd = !inst[32];
      chk("fixed_zero", {inst[33], inst[5:4]}, 0);
      cur = (inst[0] && inst[3]) ? 0 : (inst[1] && inst[3]) ? 1 : -1;
      if (m_run_len > 0 && cur != m_run_kind) begin
        chk("seg_pending", seg_len.size() != 0, 1);
        if (seg_len.size() != 0) begin
          chk("seg_kind", m_run_kind, seg_kind.pop_front());
          chk("seg_len", m_run_len, seg_len[0]);
          chk("seg_l0wr", m_wr, seg_len.pop_front());
        end
        m_wr = 0;
        if (m_run_kind == 0) begin m_in_gap = 1; m_gap = 0; end
        m_run_len = 0;
      end
      if (cur >= 0) begin m_run_kind = cur; m_run_len++; end
      if (m_in_gap) begin
        if (xrd) begin
          chk("flush_gap_ge", m_gap >= FL, 1);
          m_in_gap = 0;
        end else begin
          chk("flush_idle", {inst[6], inst[3:0], prd}, 0);
          m_gap++;
        end
      end
      if (xrd) begin
        chk("x_pending", exp_x.size() != 0, 1);
        if (exp_x.size() != 0) chk("x_addr", inst[17:7], exp_x.pop_front());
        chk("x_wen", inst[18], 1);
        chk("mode", inst[34], exp_mode);
      end
      if (inst[2]) begin
        chk("l0wr_latency", m_prev_xrd, 1);
        m_wr++;
      end
      m_prev_xrd = xrd;
      if (prd || inst[6]) begin
        chk("p_pair", {prd, !inst[31], inst[6]}, 3'b111);
        chk("p_pending", exp_p.size() != 0, 1);
        if (prd && exp_p.size() != 0) chk("p_addr", inst[30:20], exp_p.pop_front());
      end
      if (m_prev_done) chk("busy_after_done", busy, 0);
      if (done) begin
        done_cnt++;
        chk("busy_at_done", busy, 1);
      end
      m_prev_done = done;
      if (inst[1] && kij_idx == 4'd1) saw_exec_k1 = 1'b1;
    end
  end

  // Reference model: whole-layer expectations from the addressing rules.
  task automatic push_run(input int L, input int w, input int a, input int p);
    for (int k = 0; k < KI; k++) begin
      for (int i = 0; i < COL; i++) exp_x.push_back((w + k * COL + i) % AMOD);
      seg_kind.push_back(0); seg_len.push_back(COL);
      for (int i = 0; i < L; i++) exp_x.push_back((a + i) % AMOD);
      seg_kind.push_back(1); seg_len.push_back(L);
      for (int i = 0; i < L; i++) exp_p.push_back((p + k * L + i) % AMOD);
    end
  endtask

  task automatic kick(input int L, input int w, input int a, input int p, input bit m);
    @(posedge clk); #1;
    act_len = AW'(L); w_base = AW'(w); a_base = AW'(a); p_base = AW'(p);
    mode_select = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // scramble inputs: the run must use the latched copies
    act_len = AW'($urandom); w_base = AW'($urandom);
    a_base = AW'($urandom); p_base = AW'($urandom); mode_select = ~m;
  endtask

  task automatic run(input int L, input int w, input int a, input int p, input bit m, input bit poke);
    int d0, cyc;
    push_run(L, w, a, p);
    exp_mode = m;
    d0 = done_cnt;
    kick(L, w, a, p, m);
    cyc = 0;
    while (done_cnt == d0 && cyc < 20000) begin
      @(posedge clk); cyc++;
      if (poke && cyc == 40) begin
        #1; act_len = 5; w_base = 77; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; cyc++;
      end
    end
    chk("done_seen", done_cnt != d0, 1);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("busy_end", busy, 0);
    chk("kij_end", kij_idx, KI - 1);
    chk("x_left", exp_x.size(), 0);
    chk("p_left", exp_p.size(), 0);
    chk("seg_left", seg_len.size(), 0);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b0; mode_select = 1'b0; l0_full = 1'b0; ofifo_valid = 1'b0;
    act_len = '0; w_base = '0; a_base = '0; p_base = '0;
    repeat (3) @(negedge clk);
    chk("rst_inst", inst, RST_INST);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_kij", kij_idx, 0);
    @(posedge clk); #1 reset = 1'b0;

    // start with act_len==0 must be ignored
    @(posedge clk); #1;
    act_len = '0; mode_select = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    chk("zero_len_busy", busy, 0);
    chk("zero_len_inst", inst, RST_INST);
    chk("zero_len_kij", kij_idx, 0);

    rand_full = 1'b1;
    run(16, 0, 0, 100, 1'b0, 1'b0);
    run(4, 0, 200, 100, 1'b1, 1'b1);
    run(7, 2040, 2044, 2045, 1'b0, 1'b1);
    for (int r = 0; r < 3; r++)
      run($urandom_range(1, 20), $urandom_range(0, AMOD - 1), $urandom_range(0, AMOD - 1),
          $urandom_range(0, AMOD - 1), 1'($urandom_range(0, 1)), 1'b1);

    // reset in the middle of kij1 EXEC
    saw_exec_k1 = 1'b0;
    push_run(8, 10, 20, 30);
    exp_mode = 1'b0;
    kick(8, 10, 20, 30, 1'b0);
    cyc = 0;
    while (!saw_exec_k1 && cyc < 5000) begin @(posedge clk); cyc++; end
    chk("exec_k1_seen", saw_exec_k1, 1);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    chk("abort_inst", inst, RST_INST);
    chk("abort_busy", busy, 0);
    chk("abort_kij", kij_idx, 0);
    chk("abort_done", done, 0);
    exp_x.delete(); exp_p.delete(); seg_kind.delete(); seg_len.delete();
    @(posedge clk); #1 reset = 1'b0;

    run(3, 500, 600, 700, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
